// File: rtl/async_pkg.sv
// ---------------------------------------------------------------------------
// async_pkg: shared types for the four-phase bundled-data handshake library.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package async_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RTZ  = 2'd2
  } state_t;

  localparam logic TAG_CH0 = 1'b0;
  localparam logic TAG_CH1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb2_pick.sv
// ---------------------------------------------------------------------------
// arb2_pick: combinational two-way winner select. Option: ARB_MERGE2_RR_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb2_pick
  import async_pkg::*;
(
  input  logic r0,
  input  logic r1,
  output logic win
`ifdef ARB_MERGE2_RR_EN
  ,
  input  logic last
`endif
);

  always_comb begin
    win = TAG_CH0;
    if (r0 && r1) begin
`ifdef ARB_MERGE2_RR_EN
      // Contention goes to whichever channel did not win the previous transfer.
      win = (last == TAG_CH0) ? TAG_CH1 : TAG_CH0;
`else
      win = TAG_CH0;
`endif
    end else if (r1) begin
      win = TAG_CH1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/arb_merge2.sv
// ---------------------------------------------------------------------------
// arb_merge2: clocked 2-into-1 four-phase merge with source tag output.
// Option: ARB_MERGE2_RR_EN (round-robin contention; default fixed priority ch0).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_merge2
  import async_pkg::*;
#(
  parameter int unsigned N = 32'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_i,
  output logic         a0_i,
  input  logic [N-1:0] d0_i,
  input  logic         r1_i,
  output logic         a1_i,
  input  logic [N-1:0] d1_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] d_o,
  output logic         t_o
);

  state_t       state;
  state_t       state_nx;
  logic         win;
  logic         req_w;
  logic         r_nx;
  logic         a0_nx;
  logic         a1_nx;
  logic         t_nx;
  logic [N-1:0] d_nx;
`ifdef ARB_MERGE2_RR_EN
  logic         last;
  logic         last_nx;
`endif

  arb2_pick u_pick (
    .r0   (r0_i),
    .r1   (r1_i),
    .win  (win)
`ifdef ARB_MERGE2_RR_EN
    ,
    .last (last)
`endif
  );

  // t_o doubles as the registered winner for the rest of the transfer.
  assign req_w = (t_o == TAG_CH1) ? r1_i : r0_i;

  always_comb begin
    state_nx = state;
    r_nx     = r_o;
    a0_nx    = a0_i;
    a1_nx    = a1_i;
    d_nx     = d_o;
    t_nx     = t_o;
`ifdef ARB_MERGE2_RR_EN
    last_nx  = last;
`endif
    case (state)
      IDLE: begin
        if (r0_i || r1_i) begin
          d_nx     = (win == TAG_CH1) ? d1_i : d0_i;
          t_nx     = win;
          r_nx     = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (a_o) begin
          r_nx     = 1'b0;
          a0_nx    = (t_o == TAG_CH0);
          a1_nx    = (t_o == TAG_CH1);
`ifdef ARB_MERGE2_RR_EN
          last_nx  = t_o;
`endif
          state_nx = RTZ;
        end
      end
      RTZ: begin
        if (!a_o && !req_w) begin
          a0_nx    = 1'b0;
          a1_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      r_o   <= 1'b0;
      a0_i  <= 1'b0;
      a1_i  <= 1'b0;
      d_o   <= '0;
      t_o   <= TAG_CH0;
`ifdef ARB_MERGE2_RR_EN
      last  <= TAG_CH1;
`endif
    end else begin
      state <= state_nx;
      r_o   <= r_nx;
      a0_i  <= a0_nx;
      a1_i  <= a1_nx;
      d_o   <= d_nx;
      t_o   <= t_nx;
`ifdef ARB_MERGE2_RR_EN
      last  <= last_nx;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_merge2.sv
// ---------------------------------------------------------------------------
// tb_arb_merge2: randomized and directed bench for arb_merge2 against a
// transfer-level reference model. Honours ARB_MERGE2_RR_EN.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arb_merge2;

  localparam int W = 8;
`ifdef ARB_MERGE2_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         r0_i = 1'b0;
  logic         r1_i = 1'b0;
  logic         a_o = 1'b0;
  logic [W-1:0] d0_i = '0;
  logic [W-1:0] d1_i = '0;
  logic         a0_i;
  logic         a1_i;
  logic         r_o;
  logic [W-1:0] d_o;
  logic         t_o;

  always #5 clk = ~clk;

  arb_merge2 #(.N(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .r0_i (r0_i),
    .a0_i (a0_i),
    .d0_i (d0_i),
    .r1_i (r1_i),
    .a1_i (a1_i),
    .d1_i (d1_i),
    .r_o  (r_o),
    .a_o  (a_o),
    .d_o  (d_o),
    .t_o  (t_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one in-flight transfer, described as busy / acknowledged.
  bit           m_busy;
  bit           m_acked;
  bit           m_t;
  bit           m_last;
  logic [W-1:0] m_d;
  int           n_done;
  logic [W-1:0] got_d[$];
  bit           got_t[$];
  bit           prev_ro;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_acked = 1'b0;
    m_t     = 1'b0;
    m_last  = 1'b1;
    m_d     = '0;
    n_done  = 0;
    prev_ro = 1'b0;
    got_d.delete();
    got_t.delete();
  endtask

  task automatic model_step();
    bit rq[2];
    bit w;
    rq[0] = r0_i;
    rq[1] = r1_i;
    if (!m_busy) begin
      if (rq[0] || rq[1]) begin
        if (rq[0] && rq[1]) w = RR ? !m_last : 1'b0;
        else                w = rq[1];
        m_t    = w;
        m_d    = w ? d1_i : d0_i;
        m_busy = 1'b1;
      end
    end else if (!m_acked) begin
      if (a_o) begin
        m_acked = 1'b1;
        m_last  = m_t;
      end
    end else if (!a_o && !rq[m_t]) begin
      m_busy  = 1'b0;
      m_acked = 1'b0;
      n_done++;
    end
  endtask

  task automatic check_outputs();
    check("r_o", r_o, m_busy && !m_acked);
    check("a0_i", a0_i, m_acked && !m_t);
    check("a1_i", a1_i, m_acked && m_t);
    check("d_o", d_o, m_d);
    check("t_o", t_o, m_t);
    check("ack_onehot", a0_i & a1_i, 0);
  endtask

  // Environment: two four-phase producers and one consumer with random delays.
  int gap_lo, gap_hi, drop_lo, drop_hi, ack_lo, ack_hi;
  bit en[2];
  int dfix[2];
  int ps[2];
  int pc[2];
  int cc;

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic set_req(input int c, input bit v);
    logic [W-1:0] d;
    d = (dfix[c] >= 0) ? W'(dfix[c]) : W'($urandom);
    if (c == 0) begin
      r0_i = v;
      if (v) d0_i = d;
    end else begin
      r1_i = v;
      if (v) d1_i = d;
    end
  endtask

  task automatic env_update();
    bit aw[2];
    aw[0] = a0_i;
    aw[1] = a1_i;
    for (int c = 0; c < 2; c++) begin
      if (ps[c] == 1 && aw[c]) begin
        ps[c] = 2;
        pc[c] = rnd(drop_lo, drop_hi);
      end
      if (ps[c] == 2) begin
        if (pc[c] == 0) begin
          set_req(c, 1'b0);
          ps[c] = 3;
        end else pc[c]--;
      end
      if (ps[c] == 3 && !aw[c]) begin
        ps[c] = 0;
        pc[c] = rnd(gap_lo, gap_hi);
      end
      if (ps[c] == 0 && en[c]) begin
        if (pc[c] == 0) begin
          set_req(c, 1'b1);
          ps[c] = 1;
        end else pc[c]--;
      end
    end
    if (r_o && !a_o) begin
      if (cc == 0) begin
        a_o = 1'b1;
        cc  = rnd(ack_lo, ack_hi);
      end else cc--;
    end else if (!r_o && a_o) begin
      if (cc == 0) begin
        a_o = 1'b0;
        cc  = rnd(ack_lo, ack_hi);
      end else cc--;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    check_outputs();
    if (r_o && !prev_ro) begin
      got_d.push_back(d_o);
      got_t.push_back(t_o);
    end
    prev_ro = r_o;
    env_update();
  endtask

  task automatic run_until_xfers(input int target, input int bound, input string tag);
    int k = 0;
    while (n_done < target && k < bound) begin
      cycle();
      k++;
    end
    check(tag, n_done >= target, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_r_o", r_o, 0);
    check("rst_a0", a0_i, 0);
    check("rst_a1", a1_i, 0);
    check("rst_d_o", d_o, 0);
    check("rst_t_o", t_o, 0);
    r0_i = 1'b0;
    r1_i = 1'b0;
    a_o  = 1'b0;
    cc   = rnd(ack_lo, ack_hi);
    for (int c = 0; c < 2; c++) begin
      ps[c] = 0;
      pc[c] = 0;
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    env_update();
  endtask

  task automatic config_env(input bit e0, input bit e1, input int f0, input int f1,
                            input int glo, input int ghi, input int dlo, input int dhi,
                            input int alo, input int ahi);
    en[0] = e0;  en[1] = e1;
    dfix[0] = f0; dfix[1] = f1;
    gap_lo = glo; gap_hi = ghi;
    drop_lo = dlo; drop_hi = dhi;
    ack_lo = alo; ack_hi = ahi;
  endtask

  initial begin
    int k;
    model_reset();

    // Reset in the middle of a SEND, then a fresh channel-0 transfer.
    config_env(1, 0, 5, -1, 1000, 1000, 0, 0, 50, 50);
    do_reset();
    k = 0;
    while (!r_o && k < 20) begin
      cycle();
      k++;
    end
    check("send_reached", r_o, 1);
    do_reset();
    ack_lo = 2; ack_hi = 2;
    cc = 2;
    run_until_xfers(1, 60, "rst_xfer_timeout");
    check("rst_fresh_d", got_d.size() > 0 ? got_d[0] : 'x, 5);
    check("rst_fresh_t", got_t.size() > 0 ? got_t[0] : 1'bx, 0);

    // Single channel-1 transfer, consumer acks 2 cycles after r_o.
    config_env(0, 1, -1, 8'hA5, 1000, 1000, 0, 0, 2, 2);
    do_reset();
    run_until_xfers(1, 60, "ch1_xfer_timeout");
    check("ch1_d", got_d.size() > 0 ? got_d[0] : 'x, 8'hA5);
    check("ch1_t", got_t.size() > 0 ? got_t[0] : 1'bx, 1);

    // Simultaneous requests straight after reset.
    config_env(1, 1, 1, 2, 1000, 1000, 0, 1, 0, 1);
    do_reset();
    run_until_xfers(2, 100, "sim_xfer_timeout");
    check("sim_t0", got_t.size() > 1 ? got_t[0] : 1'bx, 0);
    check("sim_d0", got_d.size() > 1 ? got_d[0] : 'x, 1);
    check("sim_t1", got_t.size() > 1 ? got_t[1] : 1'bx, 1);
    check("sim_d1", got_d.size() > 1 ? got_d[1] : 'x, 2);

    // Continuous contention for 8 transfers.
    config_env(1, 1, -1, -1, 0, 0, 0, 0, 0, 0);
    do_reset();
    run_until_xfers(8, 200, "cont_xfer_timeout");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("cont_tag%0d", i), got_t.size() > i ? got_t[i] : 1'bx,
            RR ? (i % 2) : 0);
    end

    // Slow request fall: channel 0 drops its request 10 cycles after the ack.
    config_env(1, 0, -1, -1, 1000, 1000, 10, 10, 0, 0);
    do_reset();
    run_until_xfers(1, 60, "slow_xfer_timeout");

    // Randomized traffic on both channels.
    config_env(1, 1, -1, -1, 0, 4, 0, 3, 0, 3);
    do_reset();
    for (int i = 0; i < 3000; i++) cycle();
    check("rand_progress", n_done > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
